spike_detector_mc_avalon: RTL and testbench
===========================================

# spike_detector_mc_avalon

Multi-channel successor of the single-channel spike detector: monitors NB_CHANNELS parallel sample streams, tracks a running mean per channel, and flags a spike when a sample deviates from its mean by more than a programmable threshold. On detection it captures a window of WIN_DEPTH samples from the triggering channel into an internal buffer and raises an interrupt. Software configures and drains the block through an Avalon-MM slave, in the same acquisition subsystem as the existing detector.

## Interface
- NB_CHANNELS, 4: number of sample channels, 1..16.
- SAMPLE_W, 16: signed sample width, 8..16.
- WIN_DEPTH, 64: capture window length in samples, power of 2, 4..1024.
- AVG_SHIFT, 4: exponential-mean weight; mean moves by (sample-mean)>>>AVG_SHIFT.
- avl_clk_i  in  1  clock.
- avl_reset_i  in  1  reset, asynchronous, active-low.
- avl_address_i  in  14  word address.
- avl_byteenable_i  in  4  ignored.
- avl_write_i  in  1  write strobe.
- avl_writedata_i  in  16  write data.
- avl_read_i  in  1  read strobe.
- avl_readdatavalid_o  out  1  read data valid.
- avl_readdata_o  out  16  read data.
- avl_waitrequest_o  out  1  tied 0; all accesses accepted in one cycle.
- avl_irq_o  out  1  level interrupt, window ready.
- sample_i  in  NB_CHANNELS*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W].
- sample_valid_i  in  1  one strobe qualifies all channels.

## Operation
- Register map (word address): 0 ID, RO, 0x5D02; 1 CTRL/STATUS; 2 THRESHOLD, RW, unsigned 16, reset 0x0400; 3 CH_MASK, RW, NB_CHANNELS bits, reset all ones; 4 DROPPED, RO, saturating 16-bit; 6/7 TIMESTAMP lo/hi (see Configuration); 0x1000+i window sample i, sign-extended to 16. Unmapped and out-of-window reads return 0.
- CTRL write: bit0 start, bit1 stop, bit2 ack (release window), bit3 clear DROPPED. Stop wins over start when both set. STATUS read: bit0 active, bit1 window ready, bit2 capturing, bits[7:4] window channel.
- FSM: IDLE -> ARMED on start (clears all means to 0, clears ready). ARMED -> CAPTURE on a detection. CAPTURE -> READY after WIN_DEPTH samples. READY -> ARMED on ack. Stop in any state -> IDLE, discards the window. Ack outside READY is ignored. Start while active re-arms and clears the means.
- Detection: a channel is masked if its CH_MASK bit is 0. Deviation |sample-mean| is computed in SAMPLE_W+1 bits, so there is no overflow. A spike is flagged when deviation > THRESHOLD (strict). Means update on every valid sample while active, in all non-IDLE states.
- Simultaneous detections: the lowest channel index wins. Every other detecting channel increments DROPPED once. Detections in CAPTURE or READY increment DROPPED. DROPPED saturates at 0xFFFF.

## Timing
- Reset values: avl_readdatavalid_o 0, avl_readdata_o 0, avl_waitrequest_o 0, avl_irq_o 0, FSM IDLE, all means 0.
- Read accepted on cycle N gives readdatavalid=1 with data on N+1 only. A write and a read in the same cycle: the write executes, no readdatavalid.
- Sample valid on cycle N gives a registered detect flag on N+1. The trigger sample is window[0], written on N+1. Each subsequent valid sample writes the next index one cycle after its strobe.
- The last write (index WIN_DEPTH-1) on cycle M leads to state READY and avl_irq_o=1 on M+1. irq stays high until the ack write; it falls the cycle after the ack is accepted.
- Stop during CAPTURE: takes effect the next cycle, irq never rises, and the partial window reads back as stale data with ready=0.

## Configuration
- SPIKE_MC_TIMESTAMP_EN defined: a 32-bit free-running count of valid samples while active (cleared on start). Its value at the trigger sample is latched and readable at addresses 6 (lo) and 7 (hi).
- SPIKE_MC_TIMESTAMP_EN undefined: no counter logic; addresses 6 and 7 read 0.

## Structure
- Package spike_mc_pkg: register address constants, CTRL bit positions, ID value, FSM state enum (IDLE, ARMED, CAPTURE, READY).
- Sub-module spike_channel_filter: one instance per channel. It contains the mean accumulator (SAMPLE_W+AVG_SHIFT bits), the deviation compare, the registered detect flag and the registered sample copy. The top holds the FSM, arbitration, window RAM, registers and Avalon logic.

## Test plan
- Reset, read addr 0 -> 0x5D02 with readdatavalid exactly one cycle later. Read addr 2 -> 0x0400. Read addr 3 -> 0xF.
- THRESHOLD=100, start, channel 2 steps 0 -> 500 while the others stay at 0 -> irq after 64 further samples, STATUS bits[7:4]=2, window[0]=500.
- Channels 1 and 3 spike on the same strobe -> window channel=1, DROPPED=1. A spike while READY -> DROPPED=2. CTRL bit3 -> DROPPED=0.
- Stop after 10 captured samples -> irq stays 0, STATUS=0. Restart followed by a spike -> a full new window.
- CH_MASK=0xE and a spike on channel 0 -> no detection. Ack while ARMED -> no state change.
- With SPIKE_MC_TIMESTAMP_EN, a spike on the 1000th valid sample -> addr 6 reads 999, addr 7 reads 0. Without the macro, both read 0.

Source files
------------

// File: rtl/spike_mc_pkg.sv
// Shared constants for the multi-channel spike detector: register map,
// CTRL bit positions, ID value and the capture FSM state type.
package spike_mc_pkg;

    localparam logic [13:0] AddrId      = 14'h0000;
    localparam logic [13:0] AddrCtrl    = 14'h0001;
    localparam logic [13:0] AddrThresh  = 14'h0002;
    localparam logic [13:0] AddrMask    = 14'h0003;
    localparam logic [13:0] AddrDropped = 14'h0004;
    localparam logic [13:0] AddrTsLo    = 14'h0006;
    localparam logic [13:0] AddrTsHi    = 14'h0007;

    // Window samples live at 0x1000 + i.
    localparam logic [1:0]  AddrWinPage = 2'b01;

    localparam int unsigned CtrlStart   = 0;
    localparam int unsigned CtrlStop    = 1;
    localparam int unsigned CtrlAck     = 2;
    localparam int unsigned CtrlClrDrop = 3;

    localparam logic [15:0] IdValue     = 16'h5D02;
    localparam logic [15:0] ThreshReset = 16'h0400;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StReady
    } state_e;

endpackage

// File: rtl/spike_channel_filter.sv
// Per-channel running mean and spike compare. The accumulator holds the mean
// scaled by 2^AVG_SHIFT so fractional progress is kept between samples.
module spike_channel_filter #(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned AVG_SHIFT = 4
) (
    input  logic                avl_clk_i,
    input  logic                avl_reset_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    input  logic                active_i,
    input  logic                clear_i,
    input  logic                mask_i,
    input  logic [15:0]         threshold_i,
    output logic                detect_o,
    output logic [SAMPLE_W-1:0] sample_o
);

    localparam int unsigned AccW = SAMPLE_W + AVG_SHIFT;

    logic [AccW-1:0]     acc_q, acc_d;
    logic [AccW:0]       acc_sum;
    logic [SAMPLE_W-1:0] mean;
    logic [SAMPLE_W:0]   diff;
    logic [SAMPLE_W:0]   dev;
    logic [16:0]         dev_ext;
    logic                detect_q, detect_d;
    logic [SAMPLE_W-1:0] sample_q;

    assign mean    = acc_q[AccW-1:AVG_SHIFT];
    // One extra bit keeps the signed difference and its magnitude exact.
    assign diff    = {sample_i[SAMPLE_W-1], sample_i} - {mean[SAMPLE_W-1], mean};
    assign dev     = diff[SAMPLE_W] ? -diff : diff;
    assign dev_ext = 17'(dev);
    assign acc_sum = {acc_q[AccW-1], acc_q} + {{AVG_SHIFT{diff[SAMPLE_W]}}, diff};

    // Next mean and detect flag for this channel.
    always_comb begin
        acc_d    = acc_q;
        detect_d = sample_valid_i && mask_i && (dev_ext > {1'b0, threshold_i});
        if (clear_i) begin
            acc_d = '0;
        end else if (sample_valid_i && active_i) begin
            acc_d = acc_sum[AccW-1:0];
        end
    end

    // Mean accumulator, registered detect flag and sample copy.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            acc_q    <= '0;
            detect_q <= 1'b0;
            sample_q <= '0;
        end else begin
            acc_q    <= acc_d;
            detect_q <= detect_d;
            if (sample_valid_i) begin
                sample_q <= sample_i;
            end
        end
    end

    assign detect_o = detect_q;
    assign sample_o = sample_q;

endmodule

// File: rtl/spike_detector_mc_avalon.sv
// Multi-channel spike detector with window capture and Avalon-MM slave.
// Optional feature: define SPIKE_MC_TIMESTAMP_EN to add the 32-bit trigger
// timestamp at addresses 6/7; otherwise those addresses read 0.
module spike_detector_mc_avalon
    import spike_mc_pkg::*;
#(
    parameter int unsigned NB_CHANNELS = 4,
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned WIN_DEPTH   = 64,
    parameter int unsigned AVG_SHIFT   = 4
) (
    input  logic                            avl_clk_i,
    input  logic                            avl_reset_i,
    input  logic [13:0]                     avl_address_i,
    input  logic [3:0]                      avl_byteenable_i,
    input  logic                            avl_write_i,
    input  logic [15:0]                     avl_writedata_i,
    input  logic                            avl_read_i,
    output logic                            avl_readdatavalid_o,
    output logic [15:0]                     avl_readdata_o,
    output logic                            avl_waitrequest_o,
    output logic                            avl_irq_o,
    input  logic [NB_CHANNELS*SAMPLE_W-1:0] sample_i,
    input  logic                            sample_valid_i
);

    localparam int unsigned IdxW  = $clog2(WIN_DEPTH);
    localparam int unsigned MaxCh = 16;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        wr_idx_q, wr_idx_d;
    logic [3:0]             win_ch_q, win_ch_d;
    logic [15:0]            thresh_q, dropped_q, dropped_d;
    logic [NB_CHANNELS-1:0] mask_q;
    logic                   valid_q;
    logic                   rdv_q;
    logic [15:0]            rdata_q, rdata_d;
    logic [MaxCh-1:0]       det_vec;
    logic [SAMPLE_W-1:0]    chan_sample [MaxCh];
    logic [SAMPLE_W-1:0]    win_mem [WIN_DEPTH];
    logic                   mem_we;
    logic [IdxW-1:0]        mem_waddr;
    logic [SAMPLE_W-1:0]    mem_wdata;
    logic                   active, clear_means, trig, det_any;
    logic                   ctrl_wr, ctrl_start, ctrl_stop, ctrl_ack, ctrl_clr;
    logic [3:0]             low_ch;
    logic [4:0]             det_cnt, drop_inc;
    logic [16:0]            drop_sum;
    logic [15:0]            status;
    logic [31:0]            ts_rd;
    logic                   unused_byteenable;

    assign unused_byteenable = ^avl_byteenable_i;

    assign active     = (state_q != StIdle);
    assign ctrl_wr    = avl_write_i && (avl_address_i == AddrCtrl);
    assign ctrl_stop  = ctrl_wr && avl_writedata_i[CtrlStop];
    assign ctrl_start = ctrl_wr && avl_writedata_i[CtrlStart] && !avl_writedata_i[CtrlStop];
    assign ctrl_ack   = ctrl_wr && avl_writedata_i[CtrlAck];
    assign ctrl_clr   = ctrl_wr && avl_writedata_i[CtrlClrDrop];

    for (genvar c = 0; c < MaxCh; c++) begin : g_ch
        if (c < NB_CHANNELS) begin : g_live
            spike_channel_filter #(
                .SAMPLE_W  (SAMPLE_W),
                .AVG_SHIFT (AVG_SHIFT)
            ) u_filter (
                .avl_clk_i      (avl_clk_i),
                .avl_reset_i    (avl_reset_i),
                .sample_i       (sample_i[c*SAMPLE_W +: SAMPLE_W]),
                .sample_valid_i (sample_valid_i),
                .active_i       (active),
                .clear_i        (clear_means),
                .mask_i         (mask_q[c]),
                .threshold_i    (thresh_q),
                .detect_o       (det_vec[c]),
                .sample_o       (chan_sample[c])
            );
        end else begin : g_pad
            assign det_vec[c]     = 1'b0;
            assign chan_sample[c] = '0;
        end
    end

    // Lowest detecting channel wins; count all detections for DROPPED.
    always_comb begin
        low_ch  = '0;
        det_cnt = '0;
        for (int c = 15; c >= 0; c--) begin
            if (det_vec[c]) begin
                low_ch = 4'(c);
            end
            det_cnt = det_cnt + {4'b0, det_vec[c]};
        end
    end

    assign det_any = |det_vec;

    // Capture FSM next state, window write port and DROPPED increment.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        win_ch_d    = win_ch_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_idx_q;
        mem_wdata   = chan_sample[win_ch_q];
        drop_inc    = '0;
        clear_means = 1'b0;
        trig        = 1'b0;
        unique case (state_q)
            StIdle: ;
            StArmed: begin
                if (det_any) begin
                    trig      = 1'b1;
                    state_d   = StCapture;
                    win_ch_d  = low_ch;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    mem_wdata = chan_sample[low_ch];
                    wr_idx_d  = IdxW'(1);
                    drop_inc  = det_cnt - 5'd1;
                end
            end
            StCapture: begin
                drop_inc = det_cnt;
                if (valid_q) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == IdxW'(WIN_DEPTH - 1)) begin
                        state_d = StReady;
                    end
                end
            end
            StReady: begin
                drop_inc = det_cnt;
                if (ctrl_ack) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ctrl_start) begin
            state_d     = StArmed;
            wr_idx_d    = '0;
            clear_means = 1'b1;
        end
        if (ctrl_stop) begin
            state_d  = StIdle;
            wr_idx_d = '0;
            win_ch_d = '0;
        end
    end

    assign drop_sum = {1'b0, dropped_q} + {12'b0, drop_inc};

    // DROPPED saturates; a clear request beats same-cycle increments.
    always_comb begin
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (ctrl_clr) begin
            dropped_d = '0;
        end
    end

    assign status = {8'h00, win_ch_q, 1'b0, state_q == StCapture, state_q == StReady, active};

    // Read data mux; a write in the same cycle suppresses the read.
    always_comb begin
        rdata_d = '0;
        if (avl_read_i && !avl_write_i) begin
            if (avl_address_i[13:12] == AddrWinPage) begin
                if (32'(avl_address_i[11:0]) < WIN_DEPTH) begin
                    rdata_d = 16'($signed(win_mem[avl_address_i[IdxW-1:0]]));
                end
            end else begin
                case (avl_address_i)
                    AddrId:      rdata_d = IdValue;
                    AddrCtrl:    rdata_d = status;
                    AddrThresh:  rdata_d = thresh_q;
                    AddrMask:    rdata_d = 16'(mask_q);
                    AddrDropped: rdata_d = dropped_q;
                    AddrTsLo:    rdata_d = ts_rd[15:0];
                    AddrTsHi:    rdata_d = ts_rd[31:16];
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // FSM, configuration registers and Avalon read response.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            state_q   <= StIdle;
            wr_idx_q  <= '0;
            win_ch_q  <= '0;
            thresh_q  <= ThreshReset;
            mask_q    <= '1;
            dropped_q <= '0;
            valid_q   <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            win_ch_q  <= win_ch_d;
            dropped_q <= dropped_d;
            valid_q   <= sample_valid_i;
            rdv_q     <= avl_read_i && !avl_write_i;
            rdata_q   <= rdata_d;
            if (avl_write_i && (avl_address_i == AddrThresh)) begin
                thresh_q <= avl_writedata_i;
            end
            if (avl_write_i && (avl_address_i == AddrMask)) begin
                mask_q <= avl_writedata_i[NB_CHANNELS-1:0];
            end
        end
    end

    // Window RAM write port; contents survive stop and reset.
    always_ff @(posedge avl_clk_i) begin
        if (mem_we) begin
            win_mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef SPIKE_MC_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_at_q, ts_lat_q;

    // Valid-sample counter, its value at each strobe, and the trigger latch.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            ts_cnt_q <= '0;
            ts_at_q  <= '0;
            ts_lat_q <= '0;
        end else begin
            if (ctrl_start) begin
                ts_cnt_q <= '0;
            end else if (sample_valid_i && active) begin
                ts_cnt_q <= ts_cnt_q + 32'd1;
            end
            if (sample_valid_i) begin
                ts_at_q <= ts_cnt_q;
            end
            if (trig) begin
                ts_lat_q <= ts_at_q;
            end
        end
    end

    assign ts_rd = ts_lat_q;
`else
    assign ts_rd = '0;
`endif

    assign avl_readdatavalid_o = rdv_q;
    assign avl_readdata_o      = rdata_q;
    assign avl_waitrequest_o   = 1'b0;
    assign avl_irq_o           = (state_q == StReady);

endmodule

// File: tb/tb_spike_detector_mc_avalon.sv
// Directed bench for spike_detector_mc_avalon with hand-computed expectations.
module tb_spike_detector_mc_avalon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] address = '0;
    logic [3:0]  byteenable = 4'hF;
    logic        write = 1'b0;
    logic [15:0] writedata = '0;
    logic        read = 1'b0;
    logic        rdv;
    logic [15:0] rdata;
    logic        waitreq;
    logic        irq;
    logic [63:0] sample = '0;
    logic        sample_valid = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [15:0] rd;
    logic [31:0] ts_lo_exp;

    always #5 clk = ~clk;

    spike_detector_mc_avalon #(
        .NB_CHANNELS (4),
        .SAMPLE_W    (16),
        .WIN_DEPTH   (64),
        .AVG_SHIFT   (4)
    ) dut (
        .avl_clk_i           (clk),
        .avl_reset_i         (rst_n),
        .avl_address_i       (address),
        .avl_byteenable_i    (byteenable),
        .avl_write_i         (write),
        .avl_writedata_i     (writedata),
        .avl_read_i          (read),
        .avl_readdatavalid_o (rdv),
        .avl_readdata_o      (rdata),
        .avl_waitrequest_o   (waitreq),
        .avl_irq_o           (irq),
        .sample_i            (sample),
        .sample_valid_i      (sample_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] s0, input logic [15:0] s1,
                                       input logic [15:0] s2, input logic [15:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic avl_wr(input logic [13:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        address   = addr;
        writedata = data;
        write     = 1'b1;
        @(posedge clk); #1;
        write     = 1'b0;
    endtask

    // Checks that readdatavalid is low on the request cycle and high one cycle later.
    task automatic avl_rd(input logic [13:0] addr, output logic [15:0] data);
        @(posedge clk); #1;
        address = addr;
        read    = 1'b1;
        check("rdv_low_on_req", 32'(rdv), 32'd0);
        @(posedge clk); #1;
        read = 1'b0;
        check("rdv_next_cycle", 32'(rdv), 32'd1);
        data = rdata;
    endtask

    task automatic send(input logic [63:0] v);
        @(posedge clk); #1;
        sample       = v;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            send('0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdv", 32'(rdv), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_waitreq", 32'(waitreq), 32'd0);
        rst_n = 1'b1;

        avl_rd(14'h0, rd);  check("id", 32'(rd), 32'h5D02);
        avl_rd(14'h2, rd);  check("thresh_rst", 32'(rd), 32'h0400);
        avl_rd(14'h3, rd);  check("mask_rst", 32'(rd), 32'h000F);
        avl_rd(14'h1, rd);  check("status_rst", 32'(rd), 32'h0000);
        avl_rd(14'h4, rd);  check("dropped_rst", 32'(rd), 32'h0000);

        // Write and read together: write lands, no read response
        @(posedge clk); #1;
        address = 14'h2; writedata = 16'd100; write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        @(posedge clk); #1;
        check("wr_rd_no_rdv", 32'(rdv), 32'd0);
        avl_rd(14'h2, rd);  check("thresh_100", 32'(rd), 32'd100);

        // Channel 2 step 0 -> 500; trigger is window[0], 63 more fill the window
        avl_wr(14'h1, 16'h0001);
        send_zeros(2);
        send(pk(0, 0, 500, 0));
        for (int i = 1; i <= 62; i++) begin
            send(pk(0, 0, 500, 0));
            if (i == 5) begin
                avl_rd(14'h1, rd); check("status_capture_ch2", 32'(rd), 32'h0025);
            end
        end
        check("irq_before_last", 32'(irq), 32'd0);
        send(pk(0, 0, 500, 0));
        @(posedge clk); #1;
        check("irq_window_full", 32'(irq), 32'd1);
        avl_rd(14'h1, rd);    check("status_ready_ch2", 32'(rd), 32'h0023);
        avl_rd(14'h1000, rd); check("win0_ch2", 32'(rd), 32'd500);
        avl_rd(14'h1001, rd); check("win1_ch2", 32'(rd), 32'd500);

        // Simultaneous spikes on 1 and 3: channel 1 wins, one drop
        avl_wr(14'h1, 16'h0009);
        avl_rd(14'h4, rd);    check("dropped_cleared", 32'(rd), 32'd0);
        send(pk(0, 500, 0, 500));
        send_zeros(63);
        @(posedge clk); #1;
        check("irq_ch1", 32'(irq), 32'd1);
        avl_rd(14'h1, rd);    check("status_ready_ch1", 32'(rd), 32'h0013);
        avl_rd(14'h4, rd);    check("dropped_simul", 32'(rd), 32'd1);
        send(pk(500, 0, 0, 0));
        avl_rd(14'h4, rd);    check("dropped_ready", 32'(rd), 32'd2);
        avl_wr(14'h1, 16'h0008);
        avl_rd(14'h4, rd);    check("dropped_clr", 32'(rd), 32'd0);

        // Stop after 10 captured samples
        avl_wr(14'h1, 16'h0001);
        send(pk(400, 0, 0, 0));
        send_zeros(9);
        avl_wr(14'h1, 16'h0002);
        check("irq_after_stop", 32'(irq), 32'd0);
        avl_rd(14'h1, rd);    check("status_stop", 32'(rd), 32'h0000);
        send_zeros(60);
        check("irq_stays_low", 32'(irq), 32'd0);
        avl_rd(14'h1000, rd); check("win0_partial", 32'(rd), 32'd400);

        // Restart and negative spike on channel 3: full new window
        avl_wr(14'h1, 16'h0001);
        send(pk(0, 0, 0, 16'hFED4));
        send_zeros(62);
        check("irq_restart_early", 32'(irq), 32'd0);
        send_zeros(1);
        @(posedge clk); #1;
        check("irq_restart", 32'(irq), 32'd1);
        avl_rd(14'h1, rd);    check("status_ready_ch3", 32'(rd), 32'h0033);
        avl_rd(14'h1000, rd); check("win0_neg", 32'(rd), 32'hFED4);
        avl_rd(14'h103F, rd); check("win63", 32'(rd), 32'd0);
        avl_rd(14'h1040, rd); check("win_out_of_range", 32'(rd), 32'd0);
        avl_rd(14'h0005, rd); check("unmapped", 32'(rd), 32'd0);

        // Ack releases the window; irq falls the next cycle
        avl_wr(14'h1, 16'h0004);
        check("irq_ack_fall", 32'(irq), 32'd0);

        // Masked channel 0 spike is ignored; ack while ARMED does nothing
        avl_wr(14'h3, 16'h000E);
        send(pk(500, 0, 0, 0));
        send_zeros(1);
        avl_rd(14'h1, rd);    check("masked_no_detect", 32'(rd & 16'h0007), 32'h1);
        avl_rd(14'h4, rd);    check("masked_no_drop", 32'(rd), 32'd0);
        avl_wr(14'h1, 16'h0004);
        avl_rd(14'h1, rd);    check("ack_armed", 32'(rd & 16'h0007), 32'h1);

        // Spike on the 1000th valid sample after start
`ifdef SPIKE_MC_TIMESTAMP_EN
        ts_lo_exp = 32'd999;
`else
        ts_lo_exp = 32'd0;
`endif
        avl_wr(14'h3, 16'h000F);
        avl_wr(14'h1, 16'h0001);
        send_zeros(999);
        send(pk(500, 0, 0, 0));
        avl_rd(14'h1, rd);    check("ts_trigger_capture", 32'(rd & 16'h0007), 32'h5);
        avl_rd(14'h6, rd);    check("ts_lo", 32'(rd), ts_lo_exp);
        avl_rd(14'h7, rd);    check("ts_hi", 32'(rd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
